// File: rtl/lz77_dec.sv
// lz77_dec: LZ77 token decoder with a shift-register search buffer and an IDLE/COPY/LIT FSM.
module lz77_dec #(
  parameter int SBUF_DEPTH = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        code_valid,
  input  logic [3:0]  offset,
  input  logic [2:0]  match_len,
  input  logic [7:0]  char_nxt,
  output logic        code_ready,
  output logic        char_valid,
  output logic [7:0]  char_out,
  output logic [11:0] char_cnt,
  output logic        finish,
  output logic        err
);
  typedef enum logic [1:0] {IDLE, COPY, LIT} state_t;
  state_t state, state_nxt;
  logic [7:0] sbuf [SBUF_DEPTH];
  logic [7:0] sbuf_ext [16];
  logic [3:0] off_l;
  logic [2:0] rem;
  logic [7:0] char_l, last_char, cur_char;
  logic oor, accept;
  // Pad the buffer to the full 4-bit offset range so out-of-range reads yield zero.
  genvar i;
  for (i = 0; i < 16; i++) begin : g_ext
    if (i < SBUF_DEPTH) begin : g_in
      assign sbuf_ext[i] = sbuf[i];
    end else begin : g_out
      assign sbuf_ext[i] = 8'h00;
    end
  end
  assign oor        = int'(off_l) >= SBUF_DEPTH;
  assign accept     = state == IDLE && code_valid;
  assign code_ready = state == IDLE;
  assign char_valid = state != IDLE;
  assign cur_char   = state == COPY ? (oor ? 8'h00 : sbuf_ext[off_l]) : char_l;
  assign char_out   = char_valid ? cur_char : last_char;
  assign finish     = state == LIT && char_l == 8'h24;
  always_comb begin
    state_nxt = state == IDLE ? (code_valid ? (match_len != 3'd0 ? COPY : LIT) : IDLE) :
                state == COPY ? (rem == 3'd1 ? LIT : COPY) : IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_nxt;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      off_l     <= 4'd0;
      rem       <= 3'd0;
      char_l    <= 8'h00;
      last_char <= 8'h00;
      char_cnt  <= 12'd0;
      err       <= 1'b0;
      for (int k = 0; k < SBUF_DEPTH; k++) sbuf[k] <= 8'h00;
    end else begin
      if (accept) begin
        off_l  <= offset;
        rem    <= match_len;
        char_l <= char_nxt;
      end
      if (state == COPY) rem <= rem - 3'd1;
      if (char_valid) last_char <= cur_char;
      if (state == COPY && oor) err <= 1'b1;
      if (finish) begin
        char_cnt <= 12'd0;
        for (int k = 0; k < SBUF_DEPTH; k++) sbuf[k] <= 8'h00;
      end else if (char_valid) begin
        sbuf[0] <= cur_char;
        for (int k = SBUF_DEPTH - 1; k > 0; k--) sbuf[k] <= sbuf[k-1];
        if (cur_char != 8'h24) char_cnt <= char_cnt + 12'd1;
      end
    end
  end
endmodule

// File: tb/tb_lz77_dec.sv
// tb_lz77_dec: directed tokens with a scoreboard queue of expected chars checked by a monitor.
module tb_lz77_dec;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        code_valid = 1'b0;
  logic [3:0]  offset = 4'd0;
  logic [2:0]  match_len = 3'd0;
  logic [7:0]  char_nxt = 8'h00;
  logic        code_ready, char_valid, finish, err;
  logic [7:0]  char_out;
  logic [11:0] char_cnt;
  int tests = 0;
  int fails = 0;
  logic [8:0] sb [$];

  lz77_dec dut (
    .clk(clk), .reset(reset), .code_valid(code_valid), .offset(offset),
    .match_len(match_len), .char_nxt(char_nxt), .code_ready(code_ready),
    .char_valid(char_valid), .char_out(char_out), .char_cnt(char_cnt),
    .finish(finish), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic expect_char(input logic [7:0] c, input logic f);
    sb.push_back({f, c});
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!code_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!code_ready) chk("ready_timeout", {31'd0, code_ready}, 32'd1);
  endtask

  // Present a token for exactly one accepting edge; returns at the negedge after acceptance.
  task automatic send(input logic [3:0] o, input logic [2:0] l, input logic [7:0] c);
    wait_ready();
    code_valid = 1'b1;
    offset = o;
    match_len = l;
    char_nxt = c;
    @(negedge clk);
    code_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", sb.size(), 0);
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_ready"}, {31'd0, code_ready}, 32'd1);
    chk({nm, "_valid"}, {31'd0, char_valid}, 32'd0);
    chk({nm, "_out"}, {24'd0, char_out}, 32'd0);
    chk({nm, "_cnt"}, {20'd0, char_cnt}, 32'd0);
    chk({nm, "_finish"}, {31'd0, finish}, 32'd0);
    chk({nm, "_err"}, {31'd0, err}, 32'd0);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (char_valid) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_char: got %0h with no expected char at %0t", char_out, $time);
        end else begin
          logic [8:0] e;
          e = sb.pop_front();
          chk("char_out", {24'd0, char_out}, {24'd0, e[7:0]});
          chk("finish", {31'd0, finish}, {31'd0, e[8]});
        end
      end else begin
        chk("finish_idle", {31'd0, finish}, 32'd0);
      end
    end
  end

  initial begin
    int n;
    #2;
    chk_reset_vals("reset");
    @(negedge clk);
    reset = 1'b0;
    // Literal-only tokens then a back-reference: A B A B C.
    expect_char("A", 0); send(4'd0, 3'd0, "A");
    expect_char("B", 0); send(4'd0, 3'd0, "B");
    expect_char("A", 0); expect_char("B", 0); expect_char("C", 0);
    send(4'd1, 3'd2, "C");
    chk("abc_valid_1", {31'd0, char_valid}, 32'd1);
    @(negedge clk);
    chk("abc_valid_2", {31'd0, char_valid}, 32'd1);
    @(negedge clk);
    chk("abc_valid_3", {31'd0, char_valid}, 32'd1);
    drain();
    chk("abc_cnt", {20'd0, char_cnt}, 32'd5);
    // Overlapping copy repeats the single-char pattern.
    expect_char("x", 0); send(4'd0, 3'd0, "x");
    for (int k = 0; k < 6; k++) expect_char("x", 0);
    expect_char("y", 0);
    send(4'd0, 3'd6, "y");
    n = 0;
    while (!code_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("overlap_busy_cycles", n, 7);
    drain();
    chk("overlap_cnt", {20'd0, char_cnt}, 32'd13);
    // End-of-string marker.
    expect_char("1", 0); send(4'd0, 3'd0, "1");
    expect_char(8'h24, 1); send(4'd0, 3'd0, 8'h24);
    chk("eos_finish", {31'd0, finish}, 32'd1);
    chk("eos_cnt_during", {20'd0, char_cnt}, 32'd14);
    @(negedge clk);
    chk("eos_finish_drop", {31'd0, finish}, 32'd0);
    chk("eos_cnt_cleared", {20'd0, char_cnt}, 32'd0);
    expect_char(8'h00, 0); expect_char("z", 0);
    send(4'd0, 3'd1, "z");
    drain();
    chk("eos_z_cnt", {20'd0, char_cnt}, 32'd2);
    // code_valid held through a copy: second token taken exactly once.
    for (int k = 0; k < 3; k++) expect_char("z", 0);
    expect_char("m", 0); expect_char("n", 0);
    wait_ready();
    code_valid = 1'b1; offset = 4'd0; match_len = 3'd3; char_nxt = "m";
    @(negedge clk);
    offset = 4'd0; match_len = 3'd0; char_nxt = "n";
    n = 0;
    while (!code_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("hold_busy_cycles", n, 4);
    @(negedge clk);
    code_valid = 1'b0;
    drain();
    repeat (3) @(negedge clk);
    chk("hold_cnt", {20'd0, char_cnt}, 32'd7);
    // Out-of-range offset after a fresh reset.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("oor_err_clear", {31'd0, err}, 32'd0);
    expect_char(8'h00, 0); expect_char(8'h00, 0); expect_char("q", 0);
    send(4'd12, 3'd2, "q");
    drain();
    chk("oor_err_set", {31'd0, err}, 32'd1);
    chk("oor_cnt", {20'd0, char_cnt}, 32'd3);
    expect_char("r", 0); send(4'd0, 3'd0, "r");
    drain();
    chk("oor_err_sticky", {31'd0, err}, 32'd1);
    // Reset in the middle of a long copy abandons the token.
    expect_char("r", 0); expect_char("r", 0);
    send(4'd0, 3'd7, "k");
    @(negedge clk);
    #2 reset = 1'b1;
    #1 chk_reset_vals("midcopy");
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (char_valid) n++;
    end
    chk("midcopy_no_valid", n, 0);
    chk("midcopy_queue", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/lz77_dec.md
LZ77_DEC -- requirements
Module: lz77_dec

Interface
REQ-001 SHALL have port clk  input  1  rising-edge system clock.
REQ-002 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port code_valid  input  1  upstream encoder token valid.
REQ-004 SHALL have port offset  input  4  match distance into search buffer (0 = most recent char).
REQ-005 SHALL have port match_len  input  3  number of chars to copy (0..7).
REQ-006 SHALL have port char_nxt  input  8  literal following the match; 8'h24 ('$') marks end of string.
REQ-007 SHALL have port code_ready  output  1  decoder can accept a token this cycle.
REQ-008 SHALL have port char_valid  output  1  char_out holds a decoded char this cycle.
REQ-009 SHALL have port char_out  output  8  decoded char.
REQ-010 SHALL have port char_cnt  output  12  decoded chars emitted since last end-of-string, '$' excluded.
REQ-011 SHALL have port finish  output  1  one-cycle pulse when '$' is emitted.
REQ-012 SHALL have port err  output  1  sticky: copy from offset > 8 occurred.
REQ-013 SHALL have parameter SBUF_DEPTH, default 9, number of search-buffer entries (8-bit each).

Function
REQ-014 SHALL implement states IDLE, COPY, LIT.
REQ-015 IDLE: code_ready=1; token accepted when code_valid && code_ready; offset/match_len/char_nxt latched; next state COPY if match_len>0, else LIT.
REQ-016 code_ready SHALL be 0 in COPY and LIT; code_valid ignored there.
REQ-017 COPY: each cycle char_valid=1, char_out=sbuf[offset_latched]; the same char shifted into sbuf[0] (sbuf[i+1]<=sbuf[i]); remaining count decremented; after match_len cycles -> LIT.
REQ-018 Offset SHALL stay fixed during a copy; overlapping copies (offset < match_len-1) therefore repeat the pattern, as per LZ77.
REQ-019 COPY with offset_latched >= SBUF_DEPTH: char_out=8'h00, 8'h00 shifted in, err set to 1 until reset.
REQ-020 LIT: one cycle, char_valid=1, char_out=char_nxt_latched, char shifted into sbuf[0]; next state IDLE.
REQ-021 Token latency: accepted at edge T -> first char_valid in cycle T+1; token yields match_len+1 consecutive char_valid cycles; code_ready returns the cycle after LIT (throughput match_len+2 cycles/token).
REQ-022 char_cnt SHALL increment by 1 on every char_valid cycle whose char_out != 8'h24; wraps 4095 -> 0.
REQ-023 LIT with char_nxt_latched == 8'h24: finish=1 that cycle; on the same edge sbuf cleared to 0 and char_cnt cleared to 0; state IDLE.
REQ-024 8'h24 arriving via COPY SHALL be treated as ordinary data (no finish, counted).
REQ-025 char_out SHALL hold its last value when char_valid=0.

Reset
REQ-026 reset=1 SHALL immediately force state IDLE, all sbuf entries 8'h00, code_ready=1, char_valid=0, char_out=8'h00, char_cnt=0, finish=0, err=0, internal latches 0.
REQ-027 reset asserted during COPY or LIT SHALL abandon the token with no further char_valid after deassertion until a new token.

Verification
REQ-028 Bench SHALL cover: after reset, tokens (0,0,'A'),(0,0,'B'),(1,2,'C') -> chars A,B,A,B,C with char_valid each cycle; char_cnt=5.
REQ-029 Bench SHALL cover overlapping copy: (0,0,'x'),(0,6,'y') -> x,x,x,x,x,x,x,y; code_ready low for 7 cycles of second token.
REQ-030 Bench SHALL cover end marker: (0,0,'1'),(0,0,8'h24) -> '1' then '$' with finish=1 for one cycle, char_cnt=0 and sbuf all 0 next cycle; next token (0,1,'z') -> 8'h00,'z'.
REQ-031 Bench SHALL cover out-of-range: fresh reset, token (12,2,'q') -> 8'h00,8'h00,'q'; err=1 and stays 1.
REQ-032 Bench SHALL cover code_valid held high during COPY: no extra token accepted; second token consumed exactly once after return to IDLE.
REQ-033 Bench SHALL cover reset asserted mid-COPY of (0,7,'k'): outputs at reset values asynchronously, char_valid=0 until next token.
